// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit.
//   muldiv_op_t    : M-extension operation encoding carried on the op port
//   muldiv_state_t : control FSM states
//   MUL_ITERS_*    : iteration counts for 64-bit and W (32-bit) operations
//   is_w / is_signed / is_rem / is_mul : op classification helpers
//   sext32         : sign-extend a 32-bit value to 64 bits
package muldiv_unit_pkg;

    typedef enum logic [3:0] {
        OP_MUL   = 4'd0,
        OP_MULW  = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_REM   = 4'd4,
        OP_REMU  = 4'd5,
        OP_DIVW  = 4'd6,
        OP_DIVUW = 4'd7,
        OP_REMW  = 4'd8,
        OP_REMUW = 4'd9
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    localparam int MUL_ITERS_D = 64;
    localparam int MUL_ITERS_W = 32;

    function automatic logic is_w(input muldiv_op_t op);
        return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_signed(input muldiv_op_t op);
        return op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_mul(input muldiv_op_t op);
        return op inside {OP_MUL, OP_MULW};
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Restoring divider datapath, stepped one quotient bit per cycle by the parent.
//   clk       : clock, rising edge
//   load      : capture dividend/divisor magnitudes and clear the remainder
//   step      : perform one shift/compare/subtract iteration
//   w_mode    : 32-bit operation; the dividend is pre-shifted so 32 steps suffice
//   dividend  : unsigned dividend magnitude
//   divisor   : unsigned divisor magnitude
//   quotient  : unsigned quotient (valid after 64 or 32 steps)
//   remainder : unsigned remainder (valid after 64 or 32 steps)
module muldiv_unit_div_core (
    input  logic        clk,
    input  logic        load,
    input  logic        step,
    input  logic        w_mode,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    logic [63:0] rem_r;
    logic [63:0] quo_r;
    logic [63:0] dsr_r;
    logic [64:0] rem_sh;
    logic [63:0] diff;
    logic        ge;

    // The shifted partial remainder can be one bit wider than the divisor;
    // after a successful subtract it always fits back into 64 bits, so the
    // low 64 bits of the difference are exact.
    assign rem_sh = {rem_r, quo_r[63]};
    assign ge     = (rem_sh >= {1'b0, dsr_r});
    assign diff   = rem_sh[63:0] - dsr_r;

    // W dividends are at most 32 bits wide; parking them in the upper half
    // lets the same shift register produce the quotient in 32 steps.
    always_ff @(posedge clk) begin
        if (load) begin
            rem_r <= '0;
            quo_r <= w_mode ? {dividend[31:0], 32'b0} : dividend;
            dsr_r <= divisor;
        end else if (step) begin
            rem_r <= ge ? diff : rem_sh[63:0];
            quo_r <= {quo_r[62:0], ge};
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide execute unit.
//   clk, reset : clock (rising edge) and asynchronous active-high reset
//   flush      : abort any operation in flight; its result is never presented
//   in_valid   : op/a/b valid; accepted when in_ready is high
//   in_ready   : high only in IDLE
//   op         : muldiv_op_t encoding
//   a, b       : multiplicand/dividend and multiplier/divisor
//   out_valid  : result valid, held until out_ready
//   out_ready  : consumer takes the result
//   result     : final value, W ops sign-extended from bit 31; zero when not valid
//   busy       : unit is not IDLE (pipeline stall request)
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter bit FAST_SPEC = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    muldiv_state_t   state, state_n;
    logic [5:0]      counter;
    muldiv_op_t      op_in;
    logic            w_in, sgn_in, mul_in, rem_in;
    logic            a_neg_in, b_neg_in, b_zero_in, ovf_in, special_in, accept;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, dvd_op, spec_val_in;

    logic            op_w, op_mul, op_rem, q_neg, r_neg, special_r;
    logic [XLEN-1:0] spec_val_r, mcand, mplier, acc;
    logic [XLEN-1:0] quo, rem, q_fix, r_fix, raw, val;

    assign op_in  = muldiv_op_t'(op);
    assign w_in   = is_w(op_in);
    assign sgn_in = is_signed(op_in);
    assign mul_in = is_mul(op_in);
    assign rem_in = is_rem(op_in);

    // Bring both operands to op width: W ops sign- or zero-extend the low word.
    always_comb begin
        a_ext = a;
        b_ext = b;
        if (w_in) begin
            a_ext = sgn_in ? sext32(a[31:0]) : {32'b0, a[31:0]};
            b_ext = sgn_in ? sext32(b[31:0]) : {32'b0, b[31:0]};
        end
    end

    assign a_neg_in  = sgn_in & (w_in ? a[31] : a[63]);
    assign b_neg_in  = sgn_in & (w_in ? b[31] : b[63]);
    assign a_mag     = a_neg_in ? -a_ext : a_ext;
    assign b_mag     = b_neg_in ? -b_ext : b_ext;
    assign b_zero_in = w_in ? (b[31:0] == 32'h0) : (b == '0);
    assign ovf_in    = sgn_in && (w_in ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                                       : (a == {1'b1, 63'b0} && b == '1));
    assign special_in = !mul_in && (b_zero_in || ovf_in);

    // For both special cases the answer is either the dividend (as seen at op
    // width), all ones, or zero.
    assign dvd_op      = w_in ? sext32(a[31:0]) : a;
    assign spec_val_in = b_zero_in ? (rem_in ? dvd_op : '1) : (rem_in ? '0 : dvd_op);

    assign accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_n = (FAST_SPEC && special_in) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (counter == 6'd0) state_n = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        if (flush) state_n = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            counter <= '0;
        else if (flush)
            counter <= '0;
        else if (accept)
            counter <= w_in ? 6'(MUL_ITERS_W - 1) : 6'(MUL_ITERS_D - 1);
        else if (state == ST_RUN && counter != 6'd0)
            counter <= counter - 6'd1;
    end

    // Operand/op capture at accept, then radix-2 shift-add multiply while running.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_w       <= w_in;
            op_mul     <= mul_in;
            op_rem     <= rem_in;
            q_neg      <= a_neg_in ^ b_neg_in;
            r_neg      <= a_neg_in;
            special_r  <= special_in;
            spec_val_r <= spec_val_in;
            mcand      <= a_ext;
            mplier     <= b_ext;
            acc        <= '0;
        end else if (state == ST_RUN) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    muldiv_unit_div_core u_div_core (
        .clk       (clk),
        .load      (accept),
        .step      (state == ST_RUN),
        .w_mode    (w_in),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem)
    );

    assign q_fix  = q_neg ? -quo : quo;
    assign r_fix  = r_neg ? -rem : rem;
    assign raw    = op_mul ? acc : (op_rem ? r_fix : q_fix);
    assign val    = op_w ? sext32(raw[31:0]) : raw;
    // Special results bypass the iterative datapath even when the full
    // iteration count is run, so signed x/0 still yields all ones.
    assign result = (state == ST_DONE) ? (special_r ? spec_val_r : val) : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [3:0]  op;
    logic [63:0] a, b;
    logic        in_ready, out_valid, busy;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(64), .FAST_SPEC(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        @(negedge clk);
        check_int("in_ready before accept", int'(in_ready), 1);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        op       = 4'($urandom_range(0, 9));
    endtask

    // lat = 1 means out_valid is already high right after the accept edge.
    task automatic run_op(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                          output logic [63:0] res, output int lat);
        start_op(o, x, y);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for out_valid: got 0 expected 1");
        end
        res = result;
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] res;
        int          lat;
        bit          seen;

        vecs[0]  = '{OP_MUL,   64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
        vecs[1]  = '{OP_MUL,   64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001, 65};
        vecs[2]  = '{OP_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        vecs[3]  = '{OP_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        vecs[4]  = '{OP_DIVU,  64'd100, 64'd7, 64'd14, 65};
        vecs[5]  = '{OP_REMU,  64'd100, 64'd7, 64'd2, 65};
        vecs[6]  = '{OP_REM,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65};
        vecs[7]  = '{OP_DIV,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65};
        vecs[8]  = '{OP_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 65};
        vecs[9]  = '{OP_REMU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 65};
        vecs[10] = '{OP_DIV,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[11] = '{OP_REM,   64'd5, 64'd0, 64'd5, 1};
        vecs[12] = '{OP_DIVU,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[13] = '{OP_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        vecs[14] = '{OP_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
        vecs[15] = '{OP_DIVW,  64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[16] = '{OP_MULW,  64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
        vecs[17] = '{OP_MULW,  64'hDEAD_BEEF_0000_0003, 64'h1234_5678_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        vecs[18] = '{OP_DIVW,  64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        vecs[19] = '{OP_REMW,  64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        vecs[20] = '{OP_DIVUW, 64'h5555_5555_FFFF_FFFF, 64'h9999_9999_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        vecs[21] = '{OP_REMUW, 64'hABCD_0000_8000_0005, 64'h1111_1111_0000_0000, 64'hFFFF_FFFF_8000_0005, 1};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_int("reset in_ready", int'(in_ready), 1);
        check_int("reset out_valid", int'(out_valid), 0);
        check_int("reset busy", int'(busy), 0);
        check64("reset result", result, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check64($sformatf("vec%0d result", i), res, vecs[i].exp);
            check_int($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            release_result();
        end

        // Back-pressure: result and out_valid hold, no new accept.
        run_op(OP_DIVU, 64'd100, 64'd7, res, lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check64($sformatf("hold%0d result", c), result, 64'd14);
            check_int($sformatf("hold%0d out_valid", c), int'(out_valid), 1);
            check_int($sformatf("hold%0d in_ready", c), int'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = OP_DIVU; a = 64'd9; b = 64'd3;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_int("release out_valid", int'(out_valid), 0);
        check_int("release in_ready", int'(in_ready), 1);
        check_int("release busy (no accept in DONE)", int'(busy), 0);
        check64("release result cleared", result, 64'd0);

        // Flush partway through a divide.
        start_op(OP_DIV, 64'd100, 64'd7);
        repeat (19) @(posedge clk);
        #1;
        check_int("busy mid-divide", int'(busy), 1);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = OP_DIVU; a = 64'd9; b = 64'd3;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check_int("flush out_valid", int'(out_valid), 0);
        check_int("flush busy", int'(busy), 0);
        check_int("flush in_ready", int'(in_ready), 1);
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen = 1'b1;
        end
        check_int("flushed result presented", int'(seen), 0);
        run_op(OP_DIVU, 64'd9, 64'd3, res, lat);
        check64("post-flush DIVU result", res, 64'd3);
        check_int("post-flush DIVU latency", lat, 65);
        release_result();

        // Asynchronous reset in the middle of a multiply.
        start_op(OP_MUL, 64'd7, 64'd9);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_int("mid reset in_ready", int'(in_ready), 1);
        check_int("mid reset out_valid", int'(out_valid), 0);
        check_int("mid reset busy", int'(busy), 0);
        check64("mid reset result", result, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check_int("partial result after reset", int'(seen), 0);
        run_op(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, res, lat);
        check64("post-reset MUL result", res, 64'hFFFF_FFFF_FFFF_FFEB);
        check_int("post-reset MUL latency", lat, 65);
        release_result();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
